// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - completion sources and two-port CDB broadcast bundle
interface cdb_arbiter_if #(
   parameter int ROB_BITS  = 4,
   parameter int PREG_BITS = 6
);
   logic [2:0]             src_valid;
   logic [2:0]             src_ready;
   logic [3*ROB_BITS-1:0]  src_rob;
   logic [3*PREG_BITS-1:0] src_rd;
   logic [3*PREG_BITS-1:0] src_rd_old;
   logic [3*32-1:0]        src_result;
   logic [2:0]             src_regwrite;
   logic                   flush;
   logic [1:0]             cdb_valid;
   logic [2*ROB_BITS-1:0]  cdb_rob;
   logic [2*PREG_BITS-1:0] cdb_rd;
   logic [2*PREG_BITS-1:0] cdb_rd_old;
   logic [2*32-1:0]        cdb_result;
   logic [1:0]             cdb_regwrite;
   logic [3:0]             cdb_src;

   modport master (
      output src_valid, src_rob, src_rd, src_rd_old, src_result, src_regwrite, flush,
      input  src_ready, cdb_valid, cdb_rob, cdb_rd, cdb_rd_old, cdb_result, cdb_regwrite, cdb_src
   );

   modport slave (
      input  src_valid, src_rob, src_rd, src_rd_old, src_result, src_regwrite, flush,
      output src_ready, cdb_valid, cdb_rob, cdb_rd, cdb_rd_old, cdb_result, cdb_regwrite, cdb_src
   );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - three-source, two-port round-robin CDB arbiter with per-source skid buffer
module cdb_arbiter #(
   parameter int ROB_BITS  = 4,
   parameter int PREG_BITS = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   cdb_arbiter_if.slave  bus
);
   // Buffered entry layout: {regwrite, result, rd_old, rd, rob}
   localparam int RD_LSB  = ROB_BITS;
   localparam int OLD_LSB = RD_LSB + PREG_BITS;
   localparam int RES_LSB = OLD_LSB + PREG_BITS;
   localparam int RW_BIT  = RES_LSB + 32;
   localparam int W       = RW_BIT + 1;

   logic [W-1:0] src_entry [3];
   logic [W-1:0] buf_data  [3];
   logic [2:0]   buf_valid;
   logic [W-1:0] cdb_entry [2];
   logic [1:0]   cdb_valid_q;
   logic [3:0]   cdb_src_q;

   logic [1:0]   rr_ptr;
   logic [1:0]   rr_next;
   logic [2:0]   grant;
   logic [1:0]   gnt_valid;
   logic [1:0]   gnt_src [2];
   logic [1:0]   sidx;
   logic [2:0]   capture;

   function automatic logic [1:0] inc3(input logic [1:0] v);
      return (v == 2'd2) ? 2'd0 : v + 2'd1;
   endfunction

   for (genvar i = 0; i < 3; i++) begin : g_src
      assign src_entry[i] = {bus.src_regwrite[i],
                             bus.src_result[i*32 +: 32],
                             bus.src_rd_old[i*PREG_BITS +: PREG_BITS],
                             bus.src_rd[i*PREG_BITS +: PREG_BITS],
                             bus.src_rob[i*ROB_BITS +: ROB_BITS]};
   end

   // A granted buffer frees this cycle, so its source may refill at the same edge
   assign bus.src_ready = {3{!bus.flush}} & (~buf_valid | grant);
   assign capture       = bus.src_valid & bus.src_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr <= 2'd0;
      end else begin
         rr_ptr <= rr_next;
      end
   end

   always_comb begin
      rr_next = rr_ptr;
      if (gnt_valid[1]) begin
         rr_next = inc3(gnt_src[1]);
      end else if (gnt_valid[0]) begin
         rr_next = inc3(gnt_src[0]);
      end
   end

   // Walk sources in rotated priority order; first hit to port0, second to port1
   always_comb begin
      grant      = 3'b000;
      gnt_valid  = 2'b00;
      gnt_src[0] = 2'd0;
      gnt_src[1] = 2'd0;
      sidx       = 2'd0;
      for (int k = 0; k < 3; k++) begin
         sidx = 2'((int'(rr_ptr) + k) % 3);
         if (!bus.flush && buf_valid[sidx]) begin
            if (!gnt_valid[0]) begin
               gnt_valid[0] = 1'b1;
               gnt_src[0]   = sidx;
               grant[sidx]  = 1'b1;
            end else if (!gnt_valid[1]) begin
               gnt_valid[1] = 1'b1;
               gnt_src[1]   = sidx;
               grant[sidx]  = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_valid <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            buf_data[i] <= '0;
         end
      end else if (bus.flush) begin
         buf_valid <= 3'b000;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (capture[i]) begin
               buf_valid[i] <= 1'b1;
               buf_data[i]  <= src_entry[i];
            end else if (grant[i]) begin
               buf_valid[i] <= 1'b0;
            end
         end
      end
   end

   // Ungranted ports drop valid but keep their last data fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cdb_valid_q <= 2'b00;
         cdb_src_q   <= 4'd0;
         for (int p = 0; p < 2; p++) begin
            cdb_entry[p] <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            cdb_valid_q[p] <= gnt_valid[p];
            if (gnt_valid[p]) begin
               cdb_entry[p]          <= buf_data[gnt_src[p]];
               cdb_src_q[p*2 +: 2]   <= gnt_src[p];
            end
         end
      end
   end

   assign bus.cdb_valid = cdb_valid_q;
   assign bus.cdb_src   = cdb_src_q;

   for (genvar p = 0; p < 2; p++) begin : g_port
      assign bus.cdb_rob[p*ROB_BITS +: ROB_BITS]     = cdb_entry[p][0 +: ROB_BITS];
      assign bus.cdb_rd[p*PREG_BITS +: PREG_BITS]    = cdb_entry[p][RD_LSB +: PREG_BITS];
      assign bus.cdb_rd_old[p*PREG_BITS +: PREG_BITS] = cdb_entry[p][OLD_LSB +: PREG_BITS];
      assign bus.cdb_result[p*32 +: 32]              = cdb_entry[p][RES_LSB +: 32];
      assign bus.cdb_regwrite[p]                     = cdb_entry[p][RW_BIT];
   end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - scoreboard bench for cdb_arbiter with hand-computed broadcast schedule
module tb_cdb_arbiter;
   localparam int RB = 4;
   localparam int PB = 6;

   typedef struct {
      int            cyc;
      int            port;
      int            src;
      logic [RB-1:0] rob;
      logic [PB-1:0] rd;
      logic [PB-1:0] rd_old;
      logic [31:0]   result;
      logic          rw;
   } exp_t;

   typedef struct {
      int         cyc;
      logic [2:0] rdy;
   } rdy_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   seq [3] = '{0, 0, 0};
   bit   done = 1'b0;
   bit   final_done = 1'b0;
   exp_t exp_q [$];
   rdy_t rdy_q [$];

   cdb_arbiter_if #(.ROB_BITS(RB), .PREG_BITS(PB)) bus ();

   cdb_arbiter #(.ROB_BITS(RB), .PREG_BITS(PB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [RB-1:0] f_rob(input int s, input int sq);
      return RB'(sq * 3 + s);
   endfunction
   function automatic logic [PB-1:0] f_rd(input int s, input int sq);
      return PB'(sq * 5 + s + 1);
   endfunction
   function automatic logic [PB-1:0] f_old(input int s, input int sq);
      return PB'(sq * 7 + s + 2);
   endfunction
   function automatic logic [31:0] f_res(input int s, input int sq);
      return {8'(s + 1), 8'hc3, 16'(sq)};
   endfunction
   function automatic logic f_rw(input int s, input int sq);
      return ((sq + s) % 2) == 1;
   endfunction

   task automatic exp_push(input int c, input int p, input int s, input int sq);
      exp_t e;
      e.cyc = c; e.port = p; e.src = s;
      e.rob = f_rob(s, sq); e.rd = f_rd(s, sq); e.rd_old = f_old(s, sq);
      e.result = f_res(s, sq); e.rw = f_rw(s, sq);
      exp_q.push_back(e);
   endtask

   task automatic drive_src();
      for (int i = 0; i < 3; i++) begin
         bus.src_rob[i*RB +: RB]     = f_rob(i, seq[i]);
         bus.src_rd[i*PB +: PB]      = f_rd(i, seq[i]);
         bus.src_rd_old[i*PB +: PB]  = f_old(i, seq[i]);
         bus.src_result[i*32 +: 32]  = f_res(i, seq[i]);
         bus.src_regwrite[i]         = f_rw(i, seq[i]);
      end
   endtask

   // One cycle of source activity; a source holds its item until the handshake completes
   task automatic run_cycle(input logic [2:0] vld, input logic fl, input logic [2:0] exp_rdy);
      logic [2:0] acc;
      rdy_t r;
      drive_src();
      bus.src_valid = vld;
      bus.flush     = fl;
      r.cyc = cyc; r.rdy = exp_rdy;
      rdy_q.push_back(r);
      #1;
      acc = vld & bus.src_ready;
      @(posedge clk); #1;
      for (int i = 0; i < 3; i++) begin
         if (acc[i]) seq[i]++;
      end
      bus.src_valid = 3'b000;
      bus.flush     = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      rdy_t r;
      bit   here;
      logic [RB-1:0] a_rob;
      logic [PB-1:0] a_rd;
      logic [PB-1:0] a_old;
      logic [31:0]   a_res;
      logic [1:0]    a_src;
      if (!rst_n) begin
         checks++;
         if (bus.cdb_valid !== 2'b00 || bus.cdb_src !== 4'd0 || bus.cdb_rob !== '0 ||
             bus.cdb_rd !== '0 || bus.cdb_rd_old !== '0 || bus.cdb_result !== '0 ||
             bus.cdb_regwrite !== 2'b00 || bus.src_ready !== 3'b111) begin
            errors++;
            $display("FAIL reset_state cyc=%0d got valid=%b src=%h rob=%h result=%h ready=%b want zeros ready=111",
                     cyc, bus.cdb_valid, bus.cdb_src, bus.cdb_rob, bus.cdb_result, bus.src_ready);
         end
      end else begin
         while (rdy_q.size() > 0 && rdy_q[0].cyc < cyc) begin
            r = rdy_q.pop_front();
            checks++; errors++;
            $display("FAIL ready_missed cyc=%0d got no sample want ready=%b", r.cyc, r.rdy);
         end
         if (rdy_q.size() > 0 && rdy_q[0].cyc == cyc) begin
            r = rdy_q.pop_front();
            checks++;
            if (bus.src_ready !== r.rdy) begin
               errors++;
               $display("FAIL src_ready cyc=%0d got %b want %b", cyc, bus.src_ready, r.rdy);
            end
         end
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            checks++; errors++;
            $display("FAIL bc_missed cyc=%0d port=%0d got none want src=%0d", e.cyc, e.port, e.src);
         end
         checks++;
         if (bus.cdb_valid === 2'b10) begin
            errors++;
            $display("FAIL port_order cyc=%0d got cdb_valid=%b want port0 set whenever port1 is", cyc, bus.cdb_valid);
         end
         for (int p = 0; p < 2; p++) begin
            here = exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].port == p;
            if (bus.cdb_valid[p] || here) begin
               checks++;
               a_rob = bus.cdb_rob[p*RB +: RB];
               a_rd  = bus.cdb_rd[p*PB +: PB];
               a_old = bus.cdb_rd_old[p*PB +: PB];
               a_res = bus.cdb_result[p*32 +: 32];
               a_src = bus.cdb_src[p*2 +: 2];
               if (!here) begin
                  errors++;
                  $display("FAIL bc_unexpected cyc=%0d port=%0d got src=%0d rob=%h want no broadcast", cyc, p, a_src, a_rob);
               end else begin
                  e = exp_q.pop_front();
                  if (bus.cdb_valid[p] !== 1'b1) begin
                     errors++;
                     $display("FAIL bc_absent cyc=%0d port=%0d got valid=0 want src=%0d", cyc, p, e.src);
                  end else if (a_src !== 2'(e.src) || a_rob !== e.rob || a_rd !== e.rd ||
                               a_old !== e.rd_old || a_res !== e.result || bus.cdb_regwrite[p] !== e.rw) begin
                     errors++;
                     $display("FAIL bc_data cyc=%0d port=%0d got src=%0d rob=%h rd=%h old=%h res=%h rw=%b want src=%0d rob=%h rd=%h old=%h res=%h rw=%b",
                              cyc, p, a_src, a_rob, a_rd, a_old, a_res, bus.cdb_regwrite[p],
                              e.src, e.rob, e.rd, e.rd_old, e.result, e.rw);
                  end
               end
            end
         end
         if (done && !final_done) begin
            checks++;
            if (exp_q.size() != 0 || rdy_q.size() != 0) begin
               errors++;
               $display("FAIL drain got pending bc=%0d ready=%0d want 0 0", exp_q.size(), rdy_q.size());
            end
            final_done = 1'b1;
         end
      end
   end

   initial begin
      int c;
      int b0, b1, b2;
      exp_t e;
      rst_n            = 1'b0;
      bus.src_valid    = 3'b000;
      bus.flush        = 1'b0;
      bus.src_rob      = '0;
      bus.src_rd       = '0;
      bus.src_rd_old   = '0;
      bus.src_result   = '0;
      bus.src_regwrite = '0;
      #12 rst_n = 1'b1;
      @(posedge clk); #1;

      // alu1 alone: rob=3 rd=10 result=0x55, broadcast two cycles later on port0
      c = cyc;
      bus.src_rob[RB-1:0]     = 4'd3;
      bus.src_rd[PB-1:0]      = 6'd10;
      bus.src_rd_old[PB-1:0]  = 6'd7;
      bus.src_result[31:0]    = 32'h55;
      bus.src_regwrite[0]     = 1'b1;
      bus.src_valid           = 3'b001;
      e.cyc = c + 2; e.port = 0; e.src = 0; e.rob = 4'd3; e.rd = 6'd10;
      e.rd_old = 6'd7; e.result = 32'h55; e.rw = 1'b1;
      exp_q.push_back(e);
      rdy_q.push_back('{c, 3'b111});
      @(posedge clk); #1;
      bus.src_valid = 3'b000;
      idle(4);

      // mem alone moves the pointer to 0
      exp_push(cyc + 2, 0, 2, seq[2]);
      run_cycle(3'b100, 1'b0, 3'b111);
      idle(4);

      // all three at rr=0: alu1/alu2 first, mem waits one cycle
      c = cyc;
      exp_push(c + 2, 0, 0, seq[0]);
      exp_push(c + 2, 1, 1, seq[1]);
      exp_push(c + 3, 0, 2, seq[2]);
      run_cycle(3'b111, 1'b0, 3'b111);
      run_cycle(3'b000, 1'b0, 3'b011);
      run_cycle(3'b000, 1'b0, 3'b111);
      idle(3);

      // alu1 streams 8 back-to-back completions
      for (int k = 0; k < 8; k++) begin
         exp_push(cyc + 2, 0, 0, seq[0]);
         run_cycle(3'b001, 1'b0, 3'b111);
      end
      idle(4);

      // all three continuously valid for 6 cycles starting at rr=1
      c = cyc; b0 = seq[0]; b1 = seq[1]; b2 = seq[2];
      exp_push(c + 2, 0, 1, b1);     exp_push(c + 2, 1, 2, b2);
      exp_push(c + 3, 0, 0, b0);     exp_push(c + 3, 1, 1, b1 + 1);
      exp_push(c + 4, 0, 2, b2 + 1); exp_push(c + 4, 1, 0, b0 + 1);
      exp_push(c + 5, 0, 1, b1 + 2); exp_push(c + 5, 1, 2, b2 + 2);
      exp_push(c + 6, 0, 0, b0 + 2); exp_push(c + 6, 1, 1, b1 + 3);
      exp_push(c + 7, 0, 2, b2 + 3); exp_push(c + 7, 1, 0, b0 + 3);
      exp_push(c + 8, 0, 1, b1 + 4);
      run_cycle(3'b111, 1'b0, 3'b111);
      run_cycle(3'b111, 1'b0, 3'b110);
      run_cycle(3'b111, 1'b0, 3'b011);
      run_cycle(3'b111, 1'b0, 3'b101);
      run_cycle(3'b111, 1'b0, 3'b110);
      run_cycle(3'b111, 1'b0, 3'b011);
      idle(5);

      // flush with all buffers full: nothing accepted, nothing broadcast
      run_cycle(3'b111, 1'b0, 3'b111);
      run_cycle(3'b111, 1'b1, 3'b000);
      run_cycle(3'b000, 1'b0, 3'b111);
      idle(3);

      // pointer survived the flush at 2: order mem, alu1, alu2
      c = cyc;
      exp_push(c + 2, 0, 2, seq[2]);
      exp_push(c + 2, 1, 0, seq[0]);
      exp_push(c + 3, 0, 1, seq[1]);
      run_cycle(3'b111, 1'b0, 3'b111);
      run_cycle(3'b000, 1'b0, 3'b101);
      idle(3);

      // async reset mid-stream while broadcasts and a buffered entry are in flight
      run_cycle(3'b111, 1'b0, 3'b111);
      run_cycle(3'b000, 1'b0, 3'b101);
      #2 rst_n = 1'b0;
      @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      c = cyc;
      exp_push(c + 2, 0, 0, seq[0]);
      exp_push(c + 2, 1, 1, seq[1]);
      exp_push(c + 3, 0, 2, seq[2]);
      run_cycle(3'b111, 1'b0, 3'b111);
      run_cycle(3'b000, 1'b0, 3'b011);
      idle(4);

      done = 1'b1;
      @(negedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
